// File: rtl/calc_sequencer.sv
// Central controller of the BCD calculator.
// Turns key events into BCD operands and an operator, then runs the ALU over a start/done handshake.
module calc_sequencer #(
    parameter int NDIG    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic                key_ready,
    output logic [4*NDIG-1:0]   operand_a,
    output logic [4*NDIG-1:0]   operand_b,
    output logic [1:0]          alu_op,
    output logic                alu_start,
    input  logic                alu_done,
    input  logic                alu_err,
    input  logic [4*NDIG-1:0]   alu_result,
    output logic [4*NDIG-1:0]   result,
    output logic [2:0]          disp_sel,
    output logic                busy
);

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_OPA, S_OPSEL, S_OPB, S_EXEC, S_RESULT, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opA_q, opA_d, opB_q, opB_d, result_q, result_d;
    logic [CW-1:0]   cntA_q, cntA_d, cntB_q, cntB_d;
    logic [1:0]      aluOp_q, aluOp_d, pendOp_q, pendOp_d;
    logic            chain_q, chain_d, clrPend_q, clrPend_d;
    logic            aluStart_q, aluStart_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [2:0]      dispSel_q, dispSel_d;
    logic            doClear;

    logic            isDigit, isOp, isClear, isEq;
    logic [3:0]      digit;
    logic [1:0]      keyOp;

    assign isDigit = key_valid && (key_code <= 4'd9);
    assign isOp    = key_valid && (key_code == 4'hA || key_code == 4'hB ||
                                   key_code == 4'hE || key_code == 4'hF);
    assign isClear = key_valid && (key_code == 4'hC);
    assign isEq    = key_valid && (key_code == 4'hD);
    assign digit   = key_code;
    // A/B/E/F map to add/sub/mul/div through bits 2 and 0 of the code
    assign keyOp   = {key_code[2], key_code[0]};

    // Leading zeros are swallowed and a full operand ignores further digits
    function automatic logic [W-1:0] shiftVal(input logic [W-1:0] v, input logic [CW-1:0] c,
                                              input logic [3:0] d);
        if ((c == '0 && d == 4'd0) || c >= CW'(NDIG)) return v;
        return (v << 4) | W'(d);
    endfunction

    function automatic logic [CW-1:0] shiftCnt(input logic [CW-1:0] c, input logic [3:0] d);
        if ((c == '0 && d == 4'd0) || c >= CW'(NDIG)) return c;
        return c + CW'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        result_d   = result_q;
        cntA_d     = cntA_q;
        cntB_d     = cntB_q;
        aluOp_d    = aluOp_q;
        pendOp_d   = pendOp_q;
        chain_d    = chain_q;
        clrPend_d  = clrPend_q;
        aluStart_d = 1'b0;
        tmo_d      = tmo_q;
        doClear    = 1'b0;

        if (isClear && state_q != S_EXEC) begin
            doClear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (isDigit) begin
                        opA_d   = W'(digit);
                        cntA_d  = CW'(digit != 4'd0);
                        state_d = S_OPA;
                    end else if (isOp) begin
                        opA_d   = '0;
                        cntA_d  = '0;
                        aluOp_d = keyOp;
                        state_d = S_OPSEL;
                    end
                end
                S_OPA: begin
                    if (isDigit) begin
                        opA_d  = shiftVal(opA_q, cntA_q, digit);
                        cntA_d = shiftCnt(cntA_q, digit);
                    end else if (isOp) begin
                        aluOp_d = keyOp;
                        state_d = S_OPSEL;
                    end
                end
                S_OPSEL: begin
                    if (isOp) begin
                        aluOp_d = keyOp;
                    end else if (isDigit) begin
                        opB_d   = W'(digit);
                        cntB_d  = CW'(digit != 4'd0);
                        state_d = S_OPB;
                    end
                end
                S_OPB: begin
                    if (isDigit) begin
                        opB_d  = shiftVal(opB_q, cntB_q, digit);
                        cntB_d = shiftCnt(cntB_q, digit);
                    end else if (isEq || isOp) begin
                        chain_d    = isOp;
                        pendOp_d   = isOp ? keyOp : pendOp_q;
                        aluStart_d = 1'b1;
                        tmo_d      = '0;
                        clrPend_d  = 1'b0;
                        state_d    = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (isClear) clrPend_d = 1'b1;
                    // The start cycle itself never samples alu_done
                    if (alu_done && !aluStart_q) begin
                        if (clrPend_q || isClear) begin
                            doClear = 1'b1;
                        end else if (alu_err) begin
                            state_d = S_ERROR;
                        end else begin
                            result_d = alu_result;
                            if (chain_q) begin
                                opA_d   = alu_result;
                                cntA_d  = CW'(NDIG);
                                opB_d   = '0;
                                cntB_d  = '0;
                                aluOp_d = pendOp_q;
                                chain_d = 1'b0;
                                state_d = S_OPSEL;
                            end else begin
                                state_d = S_RESULT;
                            end
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        if (clrPend_q || isClear) doClear = 1'b1;
                        else state_d = S_ERROR;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                S_RESULT: begin
                    if (isOp) begin
                        opA_d   = result_q;
                        cntA_d  = CW'(NDIG);
                        opB_d   = '0;
                        cntB_d  = '0;
                        aluOp_d = keyOp;
                        state_d = S_OPSEL;
                    end else if (isDigit) begin
                        opA_d   = W'(digit);
                        cntA_d  = CW'(digit != 4'd0);
                        opB_d   = '0;
                        cntB_d  = '0;
                        state_d = S_OPA;
                    end
                end
                default: ;
            endcase
        end

        if (doClear) begin
            state_d   = S_IDLE;
            opA_d     = '0;
            opB_d     = '0;
            result_d  = '0;
            cntA_d    = '0;
            cntB_d    = '0;
            aluOp_d   = '0;
            pendOp_d  = '0;
            chain_d   = 1'b0;
            clrPend_d = 1'b0;
            tmo_d     = '0;
        end

        case (state_d)
            S_IDLE:   dispSel_d = 3'd0;
            S_OPA:    dispSel_d = 3'd1;
            S_OPSEL:  dispSel_d = 3'd2;
            S_OPB:    dispSel_d = 3'd3;
            S_RESULT: dispSel_d = 3'd4;
            S_ERROR:  dispSel_d = 3'd5;
            default:  dispSel_d = dispSel_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            result_q   <= '0;
            cntA_q     <= '0;
            cntB_q     <= '0;
            aluOp_q    <= '0;
            pendOp_q   <= '0;
            chain_q    <= 1'b0;
            clrPend_q  <= 1'b0;
            aluStart_q <= 1'b0;
            tmo_q      <= '0;
            dispSel_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            result_q   <= result_d;
            cntA_q     <= cntA_d;
            cntB_q     <= cntB_d;
            aluOp_q    <= aluOp_d;
            pendOp_q   <= pendOp_d;
            chain_q    <= chain_d;
            clrPend_q  <= clrPend_d;
            aluStart_q <= aluStart_d;
            tmo_q      <= tmo_d;
            dispSel_q  <= dispSel_d;
        end
    end

    assign busy      = (state_q == S_EXEC);
    assign key_ready = !busy;
    assign operand_a = opA_q;
    assign operand_b = opB_q;
    assign alu_op    = aluOp_q;
    assign alu_start = aluStart_q;
    assign result    = result_q;
    assign disp_sel  = dispSel_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with hand-computed expectations.
// Keys are driven on the falling edge and outputs are checked on the following falling edge.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] operand_a, operand_b, alu_result, result;
    logic [1:0]  alu_op;
    logic        alu_start, alu_done, alu_err, busy;
    logic [2:0]  disp_sel;

    int total = 0;
    int bad   = 0;

    calc_sequencer #(.NDIG(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_err    (alu_err),
        .alu_result (alu_result),
        .result     (result),
        .disp_sel   (disp_sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One key strobe, sampled on the rising edge between the two falling edges
    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic aluRespond(input logic [15:0] res, input logic err);
        alu_done   = 1'b1;
        alu_err    = err;
        alu_result = res;
        @(negedge clk);
        alu_done   = 1'b0;
        alu_err    = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        alu_done = 1'b0; alu_err = 1'b0; alu_result = 16'h0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("rst_key_ready", key_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_disp", disp_sel, 0);
        checkOutput("rst_a", operand_a, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_start", alu_start, 0);

        // 12 + 34 with done in cycle 3
        applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'hA);
        applyStimulus(4'h3); applyStimulus(4'h4);
        checkOutput("t1_disp_opb", disp_sel, 3);
        applyStimulus(4'hD);
        checkOutput("t1_start_c1", alu_start, 1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_ready", key_ready, 0);
        checkOutput("t1_a", operand_a, 16'h0012);
        checkOutput("t1_b", operand_b, 16'h0034);
        checkOutput("t1_op", alu_op, 0);
        checkOutput("t1_disp_hold", disp_sel, 3);
        @(negedge clk);
        checkOutput("t1_start_c2", alu_start, 0);
        @(negedge clk);
        aluRespond(16'h0046, 1'b0);
        checkOutput("t1_result", result, 16'h0046);
        checkOutput("t1_disp", disp_sel, 4);
        checkOutput("t1_busy_done", busy, 0);

        // digit saturation and leading zeros
        applyStimulus(4'hC);
        checkOutput("t2_clr_result", result, 0);
        applyStimulus(4'h9); applyStimulus(4'h8); applyStimulus(4'h7);
        applyStimulus(4'h6); applyStimulus(4'h5);
        checkOutput("t2_sat", operand_a, 16'h9876);
        checkOutput("t2_disp", disp_sel, 1);
        applyStimulus(4'hC);
        applyStimulus(4'h0); applyStimulus(4'h0); applyStimulus(4'h7);
        checkOutput("t2_lead0", operand_a, 16'h0007);

        // chained 5-2 then *4; a done in the start cycle is ignored
        applyStimulus(4'hC);
        applyStimulus(4'h5); applyStimulus(4'hB); applyStimulus(4'h2); applyStimulus(4'hE);
        checkOutput("t3_busy", busy, 1);
        checkOutput("t3_op_frozen", alu_op, 1);
        @(negedge clk);
        aluRespond(16'h0003, 1'b0);
        checkOutput("t3_a", operand_a, 16'h0003);
        checkOutput("t3_b", operand_b, 0);
        checkOutput("t3_op", alu_op, 2);
        checkOutput("t3_disp", disp_sel, 2);
        applyStimulus(4'h4); applyStimulus(4'hD);
        checkOutput("t3_op2", alu_op, 2);
        checkOutput("t3_b2", operand_b, 16'h0004);
        aluRespond(16'h0012, 1'b0);
        checkOutput("t3_c1_ignored", busy, 1);
        checkOutput("t3_c1_result", result, 16'h0003);
        aluRespond(16'h0012, 1'b0);
        checkOutput("t3_result2", result, 16'h0012);
        checkOutput("t3_disp2", disp_sel, 4);

        // clear while busy, then a dropped digit
        applyStimulus(4'hC);
        applyStimulus(4'h1); applyStimulus(4'hA); applyStimulus(4'h2); applyStimulus(4'hD);
        applyStimulus(4'hC);
        checkOutput("t4_ready_busy", key_ready, 0);
        applyStimulus(4'h5);
        checkOutput("t4_a_frozen", operand_a, 16'h0001);
        checkOutput("t4_still_busy", busy, 1);
        aluRespond(16'h0099, 1'b0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_disp", disp_sel, 0);
        checkOutput("t4_result", result, 0);
        checkOutput("t4_a", operand_a, 0);

        // divide by zero reports error
        applyStimulus(4'h8); applyStimulus(4'hF); applyStimulus(4'h0); applyStimulus(4'hD);
        checkOutput("t5_op", alu_op, 3);
        checkOutput("t5_b", operand_b, 0);
        @(negedge clk);
        aluRespond(16'h0000, 1'b1);
        checkOutput("t5_disp_err", disp_sel, 5);
        checkOutput("t5_busy", busy, 0);
        applyStimulus(4'h3); applyStimulus(4'hD);
        checkOutput("t5_ignored_a", operand_a, 16'h0008);
        checkOutput("t5_ignored_disp", disp_sel, 5);
        applyStimulus(4'hC);
        checkOutput("t5_clr_disp", disp_sel, 0);
        checkOutput("t5_clr_a", operand_a, 0);
        checkOutput("t5_clr_op", alu_op, 0);
        checkOutput("t5_clr_result", result, 0);

        // timeout after exactly 16 cycles
        applyStimulus(4'h1); applyStimulus(4'hA); applyStimulus(4'h1); applyStimulus(4'hD);
        repeat (15) @(negedge clk);
        checkOutput("t6_tmo_minus1", busy, 1);
        @(negedge clk);
        checkOutput("t6_tmo_busy", busy, 0);
        checkOutput("t6_tmo_disp", disp_sel, 5);
        applyStimulus(4'hC);

        // asynchronous reset in the middle of a calculation
        applyStimulus(4'h2); applyStimulus(4'hA); applyStimulus(4'h3); applyStimulus(4'hD);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_ready", key_ready, 1);
        checkOutput("t6_rst_a", operand_a, 0);
        checkOutput("t6_rst_b", operand_b, 0);
        @(negedge clk);
        resetn = 1'b1;
        aluRespond(16'h0055, 1'b0);
        checkOutput("t6_late_result", result, 0);
        checkOutput("t6_late_disp", disp_sel, 0);
        checkOutput("t6_late_start", alu_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
